width_narrow_stream: RTL

- Streaming narrowing converter. It accepts WORD_WIDTH_IN-bit words on a ready/valid interface and emits WORD_WIDTH_OUT-bit words (WORD_WIDTH_OUT < WORD_WIDTH_IN).
- Loss of significant bits is detected per word, then either saturated or truncated. Every overflow is flagged and counted.
- A 2-entry skid buffer sits between the interfaces, so arithmetic pipelines can narrow results without combinational ready paths.

---
 rtl/width_narrow_stream.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/width_narrow_stream.sv
// Narrowing stream converter: WORD_WIDTH_IN -> WORD_WIDTH_OUT words over
// ready/valid, with saturate-or-truncate overflow handling and a 2-entry skid.
//
// Ports:
//   clock, reset_n          clock, async active-low reset
//   input_valid/ready/data  upstream handshake (input_ready registered)
//   output_valid/ready/data downstream handshake (valid/data registered)
//   output_overflow         current output word lost significant bits
//   overflow_count          saturating count of overflowed words sent out
//   overflow_count_clear    synchronous counter clear
module width_narrow_stream #(
   parameter int WORD_WIDTH_IN  = 16,
   parameter int WORD_WIDTH_OUT = 8,
   parameter int SIGNED         = 0,
   parameter int SATURATE       = 1,
   parameter int COUNT_WIDTH    = 8
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      input_valid,
   output logic                      input_ready,
   input  logic [WORD_WIDTH_IN-1:0]  input_data,
   output logic                      output_valid,
   input  logic                      output_ready,
   output logic [WORD_WIDTH_OUT-1:0] output_data,
   output logic                      output_overflow,
   output logic [COUNT_WIDTH-1:0]    overflow_count,
   input  logic                      overflow_count_clear
);

   localparam int WI = WORD_WIDTH_IN;
   localparam int WO = WORD_WIDTH_OUT;
   localparam int CW = COUNT_WIDTH;

   typedef enum logic [1:0] {
      EMPTY,
      BUSY,
      FULL
   } state_t;

   state_t        r_state;
   logic [WO-1:0] r_main_data;
   logic          r_main_ovf;
   logic [WO-1:0] r_skid_data;
   logic          r_skid_ovf;
   logic          r_in_ready;
   logic          r_out_valid;
   logic [CW-1:0] r_count;

   logic          w_in_xfer;
   logic          w_out_xfer;
   logic          w_cnt_inc;
   logic          w_ovf;
   logic [WI-WO-1:0] w_hi_u;
   logic [WI-WO:0]   w_hi_s;
   logic [WO-1:0] w_sat;
   logic [WO-1:0] w_conv;

   assign w_in_xfer  = input_valid & r_in_ready;
   assign w_out_xfer = r_out_valid & output_ready;
   assign w_cnt_inc  = w_out_xfer & r_main_ovf;

   // Signed words fit only when the dropped bits and the new sign bit
   // are all copies of one value.
   always_comb begin
      w_hi_u = input_data[WI-1:WO];
      w_hi_s = input_data[WI-1:WO-1];
      if (SIGNED != 0) begin
         w_ovf = ~((&w_hi_s) | ~(|w_hi_s));
         w_sat = {input_data[WI-1], {(WO-1){~input_data[WI-1]}}};
      end else begin
         w_ovf = |w_hi_u;
         w_sat = '1;
      end
      if ((SATURATE != 0) && w_ovf) begin
         w_conv = w_sat;
      end else begin
         w_conv = input_data[WO-1:0];
      end
   end

   // Handshake outputs are registered from the next state so neither
   // ready nor valid has a combinational path through the block.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= EMPTY;
         r_main_data <= '0;
         r_main_ovf  <= 1'b0;
         r_skid_data <= '0;
         r_skid_ovf  <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         unique case (r_state)
            EMPTY: begin
               if (w_in_xfer) begin
                  r_main_data <= w_conv;
                  r_main_ovf  <= w_ovf;
                  r_state     <= BUSY;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b1;
               end
            end
            BUSY: begin
               case ({w_in_xfer, w_out_xfer})
                  2'b10: begin
                     r_skid_data <= w_conv;
                     r_skid_ovf  <= w_ovf;
                     r_state     <= FULL;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                  end
                  2'b01: begin
                     r_state     <= EMPTY;
                     r_in_ready  <= 1'b1;
                     r_out_valid <= 1'b0;
                  end
                  2'b11: begin
                     r_main_data <= w_conv;
                     r_main_ovf  <= w_ovf;
                  end
                  default: begin
                  end
               endcase
            end
            FULL: begin
               if (w_out_xfer) begin
                  r_main_data <= r_skid_data;
                  r_main_ovf  <= r_skid_ovf;
                  r_state     <= BUSY;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b1;
               end
            end
            default: begin
               r_state     <= EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Clear wins, but an overflowed word leaving on the same edge still counts.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (overflow_count_clear) begin
         r_count <= w_cnt_inc ? CW'(1) : '0;
      end else if (w_cnt_inc && (r_count != '1)) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign input_ready     = r_in_ready;
   assign output_valid    = r_out_valid;
   assign output_data     = r_main_data;
   assign output_overflow = r_main_ovf;
   assign overflow_count  = r_count;

endmodule
